// File: rtl/jt12_eg_mon_pkg.sv
// jt12_eg_mon_pkg: shared definitions for the EG monitor slice.
//   JT12_SLOTS  - operator slots per sample frame
//   JT12_SILENT - attenuation code for silence, also the "no data" read value
//   rd_state_e  - read FSM state encoding
package jt12_eg_mon_pkg;

   localparam int unsigned JT12_SLOTS  = 24;
   localparam logic [9:0]  JT12_SILENT = 10'h3FF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDone = 2'd2
   } rd_state_e;

endpackage

// File: rtl/jt12_eg_mon_if.sv
// jt12_eg_mon_if: read request/response bus of the EG monitor.
//   req, req_slot           - request strobe and operator slot (master -> slave)
//   ack, rd_data, rd_err    - one-cycle response pulse with payload (slave -> master)
//   busy                    - read pending (slave -> master)
interface jt12_eg_mon_if;

   logic       req;
   logic [4:0] req_slot;
   logic       ack;
   logic [9:0] rd_data;
   logic       rd_err;
   logic       busy;

   modport master (
      output req, req_slot,
      input  ack, rd_data, rd_err, busy
   );

   modport slave (
      input  req, req_slot,
      output ack, rd_data, rd_err, busy
   );

endinterface

// File: rtl/jt12_eg_slotcnt.sv
// jt12_eg_slotcnt: tracks which operator slot the serial EG stream carries this cycle.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_zero         - frame marker; forces the current slot to SLOT_OFS
//   i_clr          - clears the sticky sync error
//   o_slot         - slot index of the current cycle (combinational)
//   o_sync_err     - sticky: a frame marker arrived out of phase
module jt12_eg_slotcnt
   import jt12_eg_mon_pkg::*;
#(
   parameter int unsigned SLOT_OFS = 0,
   parameter int unsigned SLOTS    = JT12_SLOTS
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_zero,
   input  logic       i_clr,
   output logic [4:0] o_slot,
   output logic       o_sync_err
);

   logic [4:0] r_slot;
   logic       r_locked;
   logic       r_sync_err;
   logic [4:0] w_pred;

   always_comb begin
      w_pred = (r_slot == 5'(SLOTS - 1)) ? 5'd0 : r_slot + 5'd1;
      // The marker wins over the prediction, so a resync takes effect this cycle.
      o_slot = i_zero ? 5'(SLOT_OFS) : w_pred;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_slot     <= 5'd0;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_slot <= o_slot;
         if (i_zero) r_locked <= 1'b1;
         // The first marker after reset only aligns; later ones must land on SLOT_OFS.
         if (i_clr) begin
            r_sync_err <= 1'b0;
         end else if (i_zero && r_locked && (w_pred != 5'(SLOT_OFS))) begin
            r_sync_err <= 1'b1;
         end
      end
   end

   assign o_sync_err = r_sync_err;

endmodule

// File: rtl/jt12_eg_mon.sv
// jt12_eg_mon: EG attenuation monitor with a slot read port and a peak tracker.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_zero         - frame marker from the EG counter domain
//   i_eg_in        - serial attenuation stream, one operator per cycle
//   i_pk_slot      - slot watched by the peak tracker
//   i_pk_clr       - clears the peak level and the sync error
//   o_pk_level     - loudest (minimum) attenuation seen on i_pk_slot since clear
//   o_sync_err     - sticky frame-phase error
//   rd_bus         - read request/response bus (slave side)
module jt12_eg_mon
   import jt12_eg_mon_pkg::*;
#(
   parameter int unsigned SLOT_OFS = 0,
   parameter int unsigned SLOTS    = JT12_SLOTS
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_zero,
   input  logic [9:0]          i_eg_in,
   input  logic [4:0]          i_pk_slot,
   input  logic                i_pk_clr,
   output logic [9:0]          o_pk_level,
   output logic                o_sync_err,
   jt12_eg_mon_if.slave        rd_bus
);

   logic [4:0] w_slot;
   logic       w_req_ok;
   logic       w_pk_hit;

   rd_state_e  r_state;
   logic [4:0] r_lat;
   logic       r_ack;
   logic       r_busy;
   logic [9:0] r_rd_data;
   logic       r_rd_err;
   logic [9:0] r_pk;

   jt12_eg_slotcnt #(
      .SLOT_OFS (SLOT_OFS),
      .SLOTS    (SLOTS)
   ) u_slotcnt (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_zero     (i_zero),
      .i_clr      (i_pk_clr),
      .o_slot     (w_slot),
      .o_sync_err (o_sync_err)
   );

   assign w_req_ok = 32'(rd_bus.req_slot) < SLOTS;
   assign w_pk_hit = (i_pk_slot == w_slot) && (32'(i_pk_slot) < SLOTS);

   // DONE always ends with exactly one ack cycle. A capture from WAIT raises ack on
   // entry; an out-of-range request enters DONE with ack low and raises it one cycle
   // later, giving that path its fixed two-cycle latency.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= StIdle;
         r_lat     <= 5'd0;
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
         r_rd_data <= JT12_SILENT;
         r_rd_err  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (rd_bus.req) begin
                  if (w_req_ok) begin
                     r_lat   <= rd_bus.req_slot;
                     r_busy  <= 1'b1;
                     r_state <= StWait;
                  end else begin
                     r_rd_data <= JT12_SILENT;
                     r_rd_err  <= 1'b1;
                     r_state   <= StDone;
                  end
               end
            end
            StWait: begin
               // r_lat is only valid from the cycle after acceptance, so the
               // acceptance cycle can never match.
               if (w_slot == r_lat) begin
                  r_rd_data <= i_eg_in;
                  r_rd_err  <= 1'b0;
                  r_ack     <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= StDone;
               end
            end
            StDone: begin
               if (r_ack) begin
                  r_ack   <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  r_ack <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pk <= JT12_SILENT;
      end else if (i_pk_clr) begin
         r_pk <= JT12_SILENT;
      end else if (w_pk_hit && (i_eg_in < r_pk)) begin
         r_pk <= i_eg_in;
      end
   end

   assign o_pk_level     = r_pk;
   assign rd_bus.ack     = r_ack;
   assign rd_bus.busy    = r_busy;
   assign rd_bus.rd_data = r_rd_data;
   assign rd_bus.rd_err  = r_rd_err;

endmodule

// File: doc/jt12_eg_mon.md
JT12_EG_MON -- requirements
Module: jt12_eg_mon

Interface
REQ-001 Parameter SLOT_OFS, default 0, is the slot index (0..23) carried by eg_in in the cycle where zero=1.
REQ-002 Parameter SLOTS, default 24, is the number of time-multiplexed operator slots per sample.
REQ-003 clk  in  1  single clock; every register changes on its rising edge.
REQ-004 rst_n  in  1  reset: synchronous, active-low.
REQ-005 zero  in  1  sample-frame marker from the EG counter domain, one pulse per SLOTS cycles.
REQ-006 eg_in  in  10  serial envelope attenuation stream from the EG, one operator per cycle, 0x000 loudest, 0x3FF silent.
REQ-007 req  in  1  read request, sampled only in IDLE.
REQ-008 req_slot  in  5  operator slot to read, 0..23.
REQ-009 ack  out  1  one-cycle pulse: rd_data and rd_err are valid.
REQ-010 rd_data  out  10  captured attenuation.
REQ-011 rd_err  out  1  with ack: request was out of range.
REQ-012 busy  out  1  high while a read is pending.
REQ-013 pk_slot  in  5  slot watched by the peak tracker.
REQ-014 pk_clr  in  1  clears the peak register and the sync_err flag.
REQ-015 pk_level  out  10  minimum attenuation (loudest level) seen on pk_slot since the last clear.
REQ-016 sync_err  out  1  sticky: zero arrived out of phase.

Function
REQ-017 The slot counter is 5 bits; in a cycle with zero=1 the current slot is SLOT_OFS; otherwise it is the previous slot +1, wrapping from SLOTS-1 to 0.
REQ-018 If zero=1 arrives while the counter-predicted slot is not SLOT_OFS, the counter resynchronises in that same cycle and sync_err is set the next cycle.
REQ-019 The read FSM has three states, IDLE, WAIT and DONE.
REQ-020 IDLE: on req=1 with req_slot<SLOTS, latch req_slot, enter WAIT and assert busy from the next cycle.
REQ-021 IDLE: on req=1 with req_slot>=SLOTS, enter DONE with rd_data=0x3FF and rd_err=1.
REQ-022 WAIT: in the first cycle where the current slot equals the latched slot, capture eg_in into rd_data, set rd_err=0 and enter DONE.
REQ-023 WAIT: a match in the same cycle WAIT is entered does not count, so read latency from req to ack is 2..SLOTS+1 cycles.
REQ-024 DONE: ack=1 for exactly one cycle, busy deasserts, and the FSM returns to IDLE.
REQ-025 rd_data and rd_err hold their values until the next capture.
REQ-026 req during WAIT or DONE is ignored; no queuing.
REQ-027 A resync (REQ-018) during WAIT keeps WAIT; the capture uses the resynchronised slot number.
REQ-028 Peak tracker: each cycle where the current slot equals pk_slot and eg_in<pk_level, pk_level <= eg_in.
REQ-029 pk_clr=1 sets pk_level=0x3FF and clears sync_err; it takes priority over a same-cycle update and a same-cycle sync_err set.
REQ-030 A change of pk_slot does not clear pk_level; pk_slot>=SLOTS never updates pk_level.
REQ-031 All comparisons are unsigned 10-bit; there is no arithmetic overflow path.

Reset
REQ-032 While rst_n=0: slot counter=0, FSM=IDLE, ack=0, busy=0, rd_data=0x3FF, rd_err=0, pk_level=0x3FF, sync_err=0.
REQ-033 Reset asserted mid-read aborts the read with no ack pulse.
REQ-034 The first zero after reset aligns the counter and does not set sync_err.

Structure
REQ-035 A shared jt12 package holds the FSM state encoding, the slot-count constant (24) and the silence constant (10'h3FF).
REQ-036 Sub-module jt12_eg_slotcnt implements the slot counter, resync and sync_err detection.
REQ-037 The read FSM and the peak tracker reside in jt12_eg_mon.

Verification
REQ-038 Drive zero every 24 cycles with eg_in=slot*8; issue req with req_slot=5 two cycles after zero -> ack within 25 cycles, rd_data=0x028, rd_err=0.
REQ-039 req with req_slot=30 -> ack exactly 2 cycles after req, rd_data=0x3FF, rd_err=1.
REQ-040 pk_slot=3; feed slot 3 with values 0x300, 0x120, 0x200 over three frames -> pk_level=0x120; pulse pk_clr -> pk_level=0x3FF the next cycle.
REQ-041 After lock, pulse zero 10 cycles early -> sync_err=1 and the slot sequence restarts at SLOT_OFS; a subsequent read of slot 0 returns the resynchronised sample.
REQ-042 req accepted, then a second req while busy, then rst_n=0 mid-WAIT -> exactly zero ack pulses, busy=0, all outputs at reset values.
REQ-043 Back-to-back reads: req held high continuously -> a new request is accepted the cycle after each ack, with one ack per request and none lost.
